// File: rtl/ising_cfg_pkg.sv
// Shared definitions for the programmable coupled-cell array: FSM states,
// cfg_data field layout and weight helpers.
package ising_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_APPLY  = 2'd2
  } cfg_state_e;

  // cfg_data = {d_weight, s_weight}
  localparam int CFG_S_LSB = 0;

  function automatic int cfg_d_lsb(input int weight_w);
    return weight_w;
  endfunction

  function automatic int weight_width(input int num_weights);
    return (num_weights > 2) ? $clog2(num_weights) : 1;
  endfunction

  // Equal mismatch and match delays: the cell does not couple its two rings.
  function automatic int neutral_weight(input int num_weights);
    return (num_weights - 1) / 2;
  endfunction

  localparam int DEFAULT_NUM_WEIGHTS = 5;
  localparam int NEUTRAL_WEIGHT      = neutral_weight(DEFAULT_NUM_WEIGHTS);

endpackage

// File: rtl/coupled_cell_prog_if.sv
// Configuration port of the coupled cell: weight writes plus broadcast commit.
// A write transfers on a rising clk edge where cfg_valid && cfg_ready; the
// master holds cfg_valid/cfg_addr/cfg_data stable until that edge. cfg_commit
// is a one-cycle broadcast pulse with no handshake.
interface coupled_cell_prog_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 6
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_commit;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_commit,
    output cfg_ready
  );
endinterface

// File: rtl/coupled_cell_prog_delay_line.sv
// Tapped buffer chain used for each oscillator direction; every buffer output
// is exposed so the cell can pick its mismatch and match delays.
module buffer (
  input  logic a,
  output logic y
);
  assign y = a;
endmodule

module delay_line #(
  parameter int NUM_TAPS = 5
) (
  input  logic                din,
  output logic [NUM_TAPS-1:0] taps
);
  buffer u_buf0 (.a(din), .y(taps[0]));

  for (genvar i = 1; i < NUM_TAPS; i++) begin : g_tap
    buffer u_buf (.a(taps[i-1]), .y(taps[i]));
  end
endmodule

// File: rtl/coupled_cell_prog.sv
// Register-programmed coupled ring-oscillator cell: asynchronous weighted delay
// paths, shadow/active weight registers with commit FSM, and a mismatch counter.
module coupled_cell_prog
  import ising_cfg_pkg::*;
#(
  parameter int          NUM_WEIGHTS = 5,
  parameter int          WEIGHT_W    = weight_width(NUM_WEIGHTS),
  parameter int          ADDR_W      = 8,
  parameter int unsigned CELL_ADDR   = 0,
  parameter int          CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  coupled_cell_prog_if.slave  cfg,
  input  logic                smp_en,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    mm_count,
  input  logic                sin,
  input  logic                din,
  output logic                sout,
  output logic                dout,
  output cfg_state_e          dbg_state,
  output logic [WEIGHT_W-1:0] dbg_shadow_s,
  output logic [WEIGHT_W-1:0] dbg_shadow_d,
  output logic [WEIGHT_W-1:0] dbg_active_s,
  output logic [WEIGHT_W-1:0] dbg_active_d,
  output logic [WEIGHT_W-1:0] dbg_sel_s,
  output logic [WEIGHT_W-1:0] dbg_sel_d
);

  localparam logic [WEIGHT_W-1:0] W_NEUTRAL = WEIGHT_W'(neutral_weight(NUM_WEIGHTS));
  localparam logic [WEIGHT_W-1:0] W_MAX     = WEIGHT_W'(NUM_WEIGHTS - 1);
  localparam logic [ADDR_W-1:0]   MY_ADDR   = ADDR_W'(CELL_ADDR);
  localparam int                  D_LSB     = cfg_d_lsb(WEIGHT_W);
  localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};

  function automatic logic [WEIGHT_W-1:0] clamp_w(input logic [WEIGHT_W-1:0] w);
    return (int'(w) > NUM_WEIGHTS - 1) ? W_MAX : w;
  endfunction

  cfg_state_e          state_q, state_d;
  logic                reload_q, reload_d;
  logic [WEIGHT_W-1:0] shadow_s_q, shadow_s_d, shadow_d_q, shadow_d_d;
  logic [WEIGHT_W-1:0] apply_s_q, apply_s_d, apply_d_q, apply_d_d;
  logic [WEIGHT_W-1:0] active_s_q, active_s_d, active_d_q, active_d_d;
  logic                sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0]    mm_count_q, mm_count_d;

  logic cfg_ready;
  logic addr_hit;
  logic wr_en;
  logic commit_take;

  // State register, including all clocked datapath state of the cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      reload_q   <= 1'b0;
      shadow_s_q <= W_NEUTRAL;
      shadow_d_q <= W_NEUTRAL;
      apply_s_q  <= W_NEUTRAL;
      apply_d_q  <= W_NEUTRAL;
      active_s_q <= W_NEUTRAL;
      active_d_q <= W_NEUTRAL;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      mm_count_q <= '0;
    end else begin
      state_q    <= state_d;
      reload_q   <= reload_d;
      shadow_s_q <= shadow_s_d;
      shadow_d_q <= shadow_d_d;
      apply_s_q  <= apply_s_d;
      apply_d_q  <= apply_d_d;
      active_s_q <= active_s_d;
      active_d_q <= active_d_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      mm_count_q <= mm_count_d;
    end
  end

  // Next-state logic. reload remembers a write that landed on the commit
  // cycle, so the FSM comes back to LOADED with that write still pending.
  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_en) state_d = ST_LOADED;
      end
      ST_LOADED: begin
        if (cfg.cfg_commit) begin
          state_d  = ST_APPLY;
          reload_d = wr_en;
        end
      end
      ST_APPLY: begin
        state_d  = reload_q ? ST_LOADED : ST_IDLE;
        reload_d = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        reload_d = 1'b0;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    cfg_ready   = (state_q != ST_APPLY);
    addr_hit    = (cfg.cfg_addr == MY_ADDR);
    wr_en       = cfg.cfg_valid && cfg_ready && addr_hit;
    commit_take = (state_q == ST_LOADED) && cfg.cfg_commit;
  end

  assign cfg.cfg_ready = cfg_ready;

  // Weight registers. apply_* freezes the pre-commit shadow so a write on the
  // commit cycle cannot leak into the values being applied.
  always_comb begin
    shadow_s_d = shadow_s_q;
    shadow_d_d = shadow_d_q;
    apply_s_d  = apply_s_q;
    apply_d_d  = apply_d_q;
    active_s_d = active_s_q;
    active_d_d = active_d_q;
    if (wr_en) begin
      shadow_s_d = clamp_w(cfg.cfg_data[CFG_S_LSB +: WEIGHT_W]);
      shadow_d_d = clamp_w(cfg.cfg_data[D_LSB +: WEIGHT_W]);
    end
    if (commit_take) begin
      apply_s_d = shadow_s_q;
      apply_d_d = shadow_d_q;
    end
    if (state_q == ST_APPLY) begin
      active_s_d = apply_s_q;
      active_d_d = apply_d_q;
    end
  end

  // Mismatch synchroniser and saturating counter.
  always_comb begin
    sync1_d    = sin ^ dout;
    sync2_d    = sync1_q;
    mm_count_d = mm_count_q;
    if (cnt_clr) begin
      mm_count_d = '0;
    end else if (smp_en && sync2_q && (mm_count_q != CNT_MAX)) begin
      mm_count_d = mm_count_q + 1'b1;
    end
  end

  assign mm_count = mm_count_q;

  // Asynchronous delay paths.
  logic [NUM_WEIGHTS-1:0] s_taps, d_taps;
  logic                   mism_s, mism_d;
  logic [WEIGHT_W-1:0]    sel_s, sel_d;
  logic                   s_mux, d_mux;

  delay_line #(.NUM_TAPS(NUM_WEIGHTS)) u_dl_s (.din(sin), .taps(s_taps));
  delay_line #(.NUM_TAPS(NUM_WEIGHTS)) u_dl_d (.din(din), .taps(d_taps));

  assign mism_s = sin ^ dout;
  assign mism_d = din ^ sout;
  assign sel_s  = mism_s ? active_s_q : (W_MAX - active_s_q);
  assign sel_d  = mism_d ? active_d_q : (W_MAX - active_d_q);
  assign s_mux  = s_taps[sel_s];
  assign d_mux  = d_taps[sel_d];

  buffer u_obuf_s (.a(s_mux), .y(sout));
  buffer u_obuf_d (.a(d_mux), .y(dout));

  assign dbg_state    = state_q;
  assign dbg_shadow_s = shadow_s_q;
  assign dbg_shadow_d = shadow_d_q;
  assign dbg_active_s = active_s_q;
  assign dbg_active_d = active_d_q;
  assign dbg_sel_s    = sel_s;
  assign dbg_sel_d    = sel_d;

endmodule
